// File: rtl/spart_pkg.sv
`default_nettype none
// ============================================================================
// Package     : spart_pkg
// Description : Shared offsets, status bit positions and FSM state encoding
//               for the SPART bus master.
// Revision    : 1.0 - initial release
// ============================================================================
package spart_pkg;

    // Register offsets (in words) inside the SPART window
    localparam logic [1:0] TX_OFF   = 2'd0;
    localparam logic [1:0] RX_OFF   = 2'd1;
    localparam logic [1:0] STAT_OFF = 2'd2;

    // Status register bit positions
    localparam int RDA_BIT = 0;   // receive data available
    localparam int TBR_BIT = 1;   // transmit buffer ready

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_POLL  = 2'd1,
        ST_RD_RX = 2'd2,
        ST_WR_TX = 2'd3
    } spart_bm_state_t;

    // Absolute bus address of a register inside the window
    function automatic logic [31:0] reg_addr(input logic [31:0] base, input logic [1:0] off);
        return base + {30'd0, off};
    endfunction

endpackage
`default_nettype wire

// File: rtl/spart_bus_timer.sv
`default_nettype none
// ============================================================================
// Module      : spart_bus_timer
// Description : Request timeout counter. Counts cycles a bus request waits
//               without acknowledge and flags expiry on the last allowed one.
// Revision    : 1.0 - initial release
// ============================================================================
module spart_bus_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,     // restart from zero (state entry)
    input  logic en_i,      // request held and not acknowledged this cycle
    output logic expire_o   // this un-acked cycle is the last one allowed
);

    // TIMEOUT-1 is the largest value ever held, so $clog2(TIMEOUT) bits suffice
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] count_q;

    // Wait counter: clear has priority, otherwise count un-acked cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clr_i) begin
            count_q <= '0;
        end else if (en_i) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign expire_o = en_i && (count_q == CNT_W'(TIMEOUT - 1));

endmodule
`default_nettype wire

// File: rtl/spart_bus_master.sv
`default_nettype none
// ============================================================================
// Module      : spart_bus_master
// Description : Bus initiator for the SPART register window. Polls status,
//               writes pending TX bytes, drains RX bytes into a local stream,
//               and aborts any request that is not acknowledged in time.
// Revision    : 1.0 - initial release
// ============================================================================
module spart_bus_master
    import spart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_001C,
    parameter int          POLL_GAP  = 4,
    parameter int          TIMEOUT   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic        write_o,
    output logic        read_o,
    output logic [31:0] addr_o,
    output logic [31:0] data_o,
    input  logic [31:0] data_i,
    input  logic        ack_i,
    output logic        err_o
);

    localparam int GAP_W = $clog2(POLL_GAP + 1) + 1;

    spart_bm_state_t state_q, state_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             tx_pend_q, tx_pend_d;
    logic [7:0]       tx_byte_q, tx_byte_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             err_q, err_d;

    logic req_active;
    logic timer_clr;
    logic timer_expire;
    logic data_hi_unused;

    // Only the low byte of read data carries status or RX payload
    assign data_hi_unused = ^data_i[31:8];

    assign req_active = (state_q != ST_IDLE);
    assign timer_clr  = (state_d != state_q);

    spart_bus_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (timer_clr),
        .en_i     (req_active && !ack_i),
        .expire_o (timer_expire)
    );

    // State and storage registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            gap_q      <= '0;
            tx_pend_q  <= 1'b0;
            tx_byte_q  <= 8'h00;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            gap_q      <= gap_d;
            tx_pend_q  <= tx_pend_d;
            tx_byte_q  <= tx_byte_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            err_q      <= err_d;
        end
    end

    // Next-state logic: stream handshakes, bus sequencing and timeout abort
    always_comb begin
        state_d    = state_q;
        tx_pend_d  = tx_pend_q;
        tx_byte_d  = tx_byte_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        err_d      = 1'b0;

        // TX holding register refills only once the previous byte is gone
        if (tx_valid && !tx_pend_q) begin
            tx_pend_d = 1'b1;
            tx_byte_d = tx_data;
        end

        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (gap_q == GAP_W'(POLL_GAP)) begin
                    state_d = ST_POLL;
                end
            end
            ST_POLL: begin
                if (ack_i) begin
                    // RX first so the SPART receive buffer cannot overrun
                    if (data_i[RDA_BIT] && !rx_valid_q) begin
                        state_d = ST_RD_RX;
                    end else if (data_i[TBR_BIT] && tx_pend_q) begin
                        state_d = ST_WR_TX;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (timer_expire) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end
            end
            ST_RD_RX: begin
                if (ack_i) begin
                    rx_data_d  = data_i[7:0];
                    rx_valid_d = 1'b1;
                    state_d    = ST_IDLE;
                end else if (timer_expire) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end
            end
            ST_WR_TX: begin
                if (ack_i) begin
                    tx_pend_d = 1'b0;
                    state_d   = ST_IDLE;
                end else if (timer_expire) begin
                    // Byte stays pending and is retried after a fresh poll
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Gap counter runs only while staying in IDLE, so entry sees zero
        if (state_q == ST_IDLE && state_d == ST_IDLE) begin
            gap_d = gap_q + 1'b1;
        end else begin
            gap_d = '0;
        end
    end

    // Moore decode of the bus request from registered state
    always_comb begin
        write_o = 1'b0;
        read_o  = 1'b0;
        addr_o  = 32'h0;
        data_o  = 32'h0;
        case (state_q)
            ST_POLL: begin
                read_o = 1'b1;
                addr_o = reg_addr(BASE_ADDR, STAT_OFF);
            end
            ST_RD_RX: begin
                read_o = 1'b1;
                addr_o = reg_addr(BASE_ADDR, RX_OFF);
            end
            ST_WR_TX: begin
                write_o = 1'b1;
                addr_o  = reg_addr(BASE_ADDR, TX_OFF);
                data_o  = {24'h0, tx_byte_q};
            end
            default: begin
            end
        endcase
    end

    assign tx_ready = !tx_pend_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign err_o    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_spart_bus_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_spart_bus_master
// Description : Self-checking bench for spart_bus_master with a behavioural
//               SPART target and a scoreboard of completed TX/RX accesses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spart_bus_master;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } xact_t;

    logic        clk;
    logic        rst_n;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        write_o;
    logic        read_o;
    logic [31:0] addr_o;
    logic [31:0] data_o;
    logic [31:0] data_i;
    logic        ack_i;
    logic        err_o;

    // Target model controls (written by the tests only)
    logic        ack_en;
    logic        wr_ack_en;
    logic        rda;
    logic        tbr;
    logic [7:0]  rx_byte;
    int          zero_until;

    // Target model observations (written by the responder only)
    int          poll_cnt;
    int          wr_cycles;
    int          wr_poll;
    xact_t       obs_q[$];

    // Scoreboard and counters (written by the tests only)
    xact_t       exp_q[$];
    int          obs_idx;
    int          checks;
    int          errors;

    spart_bus_master #(
        .BASE_ADDR (32'h0000_001C),
        .POLL_GAP  (0),
        .TIMEOUT   (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .write_o  (write_o),
        .read_o   (read_o),
        .addr_o   (addr_o),
        .data_o   (data_o),
        .data_i   (data_i),
        .ack_i    (ack_i),
        .err_o    (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SPART target: answers on the falling edge, logs completed TX/RX accesses
    initial begin
        ack_i     = 1'b0;
        data_i    = 32'h0;
        poll_cnt  = 0;
        wr_cycles = 0;
        wr_poll   = 0;
    end

    always @(negedge clk) begin
        ack_i  = 1'b0;
        data_i = 32'h0;
        if (rst_n && (read_o || write_o)) begin
            if (write_o) wr_cycles++;
            if (read_o && addr_o == 32'h1E) begin
                data_i = (poll_cnt < zero_until) ? 32'h0 : {30'd0, tbr, rda};
                if (ack_en) begin
                    ack_i = 1'b1;
                    poll_cnt++;
                end
            end else if (read_o) begin
                data_i = {24'h0, rx_byte};
                if (ack_en) begin
                    ack_i = 1'b1;
                    obs_q.push_back('{wr: 1'b0, addr: addr_o, data: data_i});
                end
            end else if (ack_en && wr_ack_en) begin
                ack_i   = 1'b1;
                wr_poll = poll_cnt;
                obs_q.push_back('{wr: 1'b1, addr: addr_o, data: data_o});
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_tx(input logic [7:0] b);
        int n = 0;
        tx_data  = b;
        tx_valid = 1'b1;
        while (!tx_ready && n < 50) begin
            cyc();
            n++;
        end
        checks++;
        if (tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL push_tx_ready: tx_ready=%b, expected 1 within 50 cycles", tx_ready);
        end
        cyc();
        tx_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) cyc();
        checks++;
        if ({write_o, read_o, err_o, rx_valid} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_strobes: wr=%b rd=%b err=%b rxv=%b, expected all 0",
                     write_o, read_o, err_o, rx_valid);
        end
        checks++;
        if (addr_o !== 32'h0 || data_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_bus: addr=%h data=%h, expected 0/0", addr_o, data_o);
        end
        checks++;
        if (tx_ready !== 1'b1 || rx_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_stream: tx_ready=%b rx_data=%h, expected 1/00", tx_ready, rx_data);
        end
        rst_n = 1'b1;
        cyc();
        checks++;
        if (read_o !== 1'b1 || addr_o !== 32'h1E || write_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_first_poll: rd=%b addr=%h wr=%b, expected 1/0000001e/0",
                     read_o, addr_o, write_o);
        end
        repeat (4) cyc();
    endtask

    task automatic test_tx_basic();
        int k = 0;
        int wb;
        tbr = 1'b1;
        rda = 1'b0;
        cyc();
        wb = wr_cycles;
        exp_q.push_back('{wr: 1'b1, addr: 32'h1C, data: 32'h0000_00A5});
        push_tx(8'hA5);
        while (!tx_ready && k < 10) begin
            cyc();
            k++;
        end
        checks++;
        if (k < 2 || k > 3) begin
            errors++;
            $display("FAIL tx_basic_latency: tx_ready back after %0d edges, expected 2..3", k);
        end
        repeat (6) cyc();
        checks++;
        if (wr_cycles - wb !== 1) begin
            errors++;
            $display("FAIL tx_basic_strobe: write_o high %0d cycles, expected 1", wr_cycles - wb);
        end
        while (exp_q.size() > 0) begin
            xact_t e = exp_q.pop_front();
            checks++;
            if (obs_idx >= obs_q.size()) begin
                errors++;
                $display("FAIL tx_basic_xact: none, expected wr=%b addr=%h data=%h", e.wr, e.addr, e.data);
            end else begin
                if (obs_q[obs_idx] !== e) begin
                    errors++;
                    $display("FAIL tx_basic_xact: wr=%b addr=%h data=%h, expected wr=%b addr=%h data=%h",
                             obs_q[obs_idx].wr, obs_q[obs_idx].addr, obs_q[obs_idx].data, e.wr, e.addr, e.data);
                end
                obs_idx++;
            end
        end
    endtask

    task automatic test_tx_backpressure();
        int base;
        int rdy_hi = 0;
        int n = 0;
        tbr = 1'b0;
        push_tx(8'h77);
        exp_q.push_back('{wr: 1'b1, addr: 32'h1C, data: 32'h0000_0077});
        base       = poll_cnt;
        zero_until = poll_cnt + 3;
        tbr        = 1'b1;
        while (obs_q.size() <= obs_idx && n < 60) begin
            if (tx_ready) rdy_hi++;
            cyc();
            n++;
        end
        checks++;
        if (rdy_hi != 0) begin
            errors++;
            $display("FAIL bp_tx_ready: tx_ready high %0d cycles before write, expected 0", rdy_hi);
        end
        checks++;
        if (wr_poll != base + 4) begin
            errors++;
            $display("FAIL bp_poll_count: write after poll %0d, expected poll %0d", wr_poll - base, 4);
        end
        repeat (6) cyc();
        while (exp_q.size() > 0) begin
            xact_t e = exp_q.pop_front();
            checks++;
            if (obs_idx >= obs_q.size()) begin
                errors++;
                $display("FAIL bp_xact: none, expected wr=%b addr=%h data=%h", e.wr, e.addr, e.data);
            end else begin
                if (obs_q[obs_idx] !== e) begin
                    errors++;
                    $display("FAIL bp_xact: wr=%b addr=%h data=%h, expected wr=%b addr=%h data=%h",
                             obs_q[obs_idx].wr, obs_q[obs_idx].addr, obs_q[obs_idx].data, e.wr, e.addr, e.data);
                end
                obs_idx++;
            end
        end
        checks++;
        if (obs_q.size() != obs_idx || tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_after: extra accesses=%0d tx_ready=%b, expected 0/1", obs_q.size() - obs_idx, tx_ready);
        end
    endtask

    task automatic test_rx_priority();
        tbr     = 1'b0;
        rda     = 1'b0;
        rx_byte = 8'h3C;
        push_tx(8'h11);
        exp_q.push_back('{wr: 1'b0, addr: 32'h1D, data: 32'h0000_003C});
        exp_q.push_back('{wr: 1'b1, addr: 32'h1C, data: 32'h0000_0011});
        rda = 1'b1;
        tbr = 1'b1;
        repeat (20) cyc();
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h3C) begin
            errors++;
            $display("FAIL rx_hold: rx_valid=%b rx_data=%h, expected 1/3c", rx_valid, rx_data);
        end
        while (exp_q.size() > 0) begin
            xact_t e = exp_q.pop_front();
            checks++;
            if (obs_idx >= obs_q.size()) begin
                errors++;
                $display("FAIL rx_xact: none, expected wr=%b addr=%h data=%h", e.wr, e.addr, e.data);
            end else begin
                if (obs_q[obs_idx] !== e) begin
                    errors++;
                    $display("FAIL rx_xact: wr=%b addr=%h data=%h, expected wr=%b addr=%h data=%h",
                             obs_q[obs_idx].wr, obs_q[obs_idx].addr, obs_q[obs_idx].data, e.wr, e.addr, e.data);
                end
                obs_idx++;
            end
        end
        checks++;
        if (obs_q.size() != obs_idx) begin
            errors++;
            $display("FAIL rx_no_second_read: %0d extra accesses, expected 0", obs_q.size() - obs_idx);
        end
        rda      = 1'b0;
        rx_ready = 1'b1;
        cyc();
        checks++;
        if (rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL rx_clear: rx_valid=%b one cycle after rx_ready, expected 0", rx_valid);
        end
        rx_ready = 1'b0;
        repeat (4) cyc();
    endtask

    task automatic test_timeout();
        int n   = 0;
        int run = 0;
        int errs = 0;
        tbr = 1'b0;
        rda = 1'b0;
        push_tx(8'h55);
        ack_en = 1'b0;
        while (!read_o && n < 20) begin
            cyc();
            n++;
        end
        while (read_o && run < 40) begin
            if (err_o) errs++;
            cyc();
            run++;
        end
        checks++;
        if (read_o !== 1'b0 || write_o !== 1'b0) begin
            errors++;
            $display("FAIL to_idle: rd=%b wr=%b after timeout, expected 0/0", read_o, write_o);
        end
        repeat (3) begin
            if (err_o) errs++;
            cyc();
        end
        checks++;
        if (run != 8) begin
            errors++;
            $display("FAIL to_read_len: read_o high %0d cycles, expected 8", run);
        end
        checks++;
        if (errs != 1) begin
            errors++;
            $display("FAIL to_err_pulse: err_o high %0d cycles, expected 1", errs);
        end
        checks++;
        if (tx_ready !== 1'b0) begin
            errors++;
            $display("FAIL to_tx_kept: tx_ready=%b, expected 0 (byte retained)", tx_ready);
        end
        exp_q.push_back('{wr: 1'b1, addr: 32'h1C, data: 32'h0000_0055});
        tbr    = 1'b1;
        ack_en = 1'b1;
        n      = 0;
        while (obs_q.size() <= obs_idx && n < 40) begin
            cyc();
            n++;
        end
        while (exp_q.size() > 0) begin
            xact_t e = exp_q.pop_front();
            checks++;
            if (obs_idx >= obs_q.size()) begin
                errors++;
                $display("FAIL to_retry_xact: none, expected wr=%b addr=%h data=%h", e.wr, e.addr, e.data);
            end else begin
                if (obs_q[obs_idx] !== e) begin
                    errors++;
                    $display("FAIL to_retry_xact: wr=%b addr=%h data=%h, expected wr=%b addr=%h data=%h",
                             obs_q[obs_idx].wr, obs_q[obs_idx].addr, obs_q[obs_idx].data, e.wr, e.addr, e.data);
                end
                obs_idx++;
            end
        end
        repeat (4) cyc();
    endtask

    task automatic test_async_reset();
        int n = 0;
        tbr       = 1'b1;
        wr_ack_en = 1'b0;
        push_tx(8'h99);
        while (!write_o && n < 20) begin
            cyc();
            n++;
        end
        checks++;
        if (write_o !== 1'b1) begin
            errors++;
            $display("FAIL ar_reach_write: write_o=%b, expected 1 within 20 cycles", write_o);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (write_o !== 1'b0 || addr_o !== 32'h0 || data_o !== 32'h0) begin
            errors++;
            $display("FAIL ar_drop: wr=%b addr=%h data=%h before edge, expected 0/0/0", write_o, addr_o, data_o);
        end
        cyc();
        rst_n     = 1'b1;
        wr_ack_en = 1'b1;
        checks++;
        if (tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL ar_tx_ready: tx_ready=%b after release, expected 1", tx_ready);
        end
        repeat (10) cyc();
        checks++;
        if (obs_q.size() != obs_idx || tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL ar_byte_lost: %0d accesses tx_ready=%b, expected 0/1", obs_q.size() - obs_idx, tx_ready);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        tx_data    = 8'h00;
        tx_valid   = 1'b0;
        rx_ready   = 1'b0;
        ack_en     = 1'b1;
        wr_ack_en  = 1'b1;
        rda        = 1'b0;
        tbr        = 1'b0;
        rx_byte    = 8'h00;
        zero_until = 0;
        obs_idx    = 0;
        checks     = 0;
        errors     = 0;

        test_reset();
        test_tx_basic();
        test_tx_backpressure();
        test_rx_priority();
        test_timeout();
        test_async_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spart_bus_master.md
# spart_bus_master

Memory-mapped bus initiator that drives the SPART register window from the processor-side fabric. It polls the SPART status register, moves bytes from a local valid/ready TX stream into the SPART TX register, and drains received bytes from the SPART RX register into a local valid/ready RX stream. Each bus access is a single request held until acknowledge, with a timeout that flags an unresponsive target.

## Interface
Parameters:
- BASE_ADDR, 32'h0000_001C: SPART window base, word-aligned. TX is at +0, RX at +1, status at +2.
- POLL_GAP, 4: idle cycles between status polls. A value of 0 means one IDLE cycle.
- TIMEOUT, 16: maximum cycles a request is held without ack_i. Must be at least 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- tx_data  in  8  byte to transmit.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  block accepts tx_data this cycle.
- rx_data  out  8  received byte.
- rx_valid  out  1  rx_data is valid.
- rx_ready  in  1  consumer takes rx_data this cycle.
- write_o  out  1  bus write request.
- read_o  out  1  bus read request.
- addr_o  out  32  bus address.
- data_o  out  32  bus write data, always {24'h0, byte}.
- data_i  in  32  bus read data.
- ack_i  in  1  target acknowledge, sampled on the rising edge.
- err_o  out  1  one-cycle pulse on a bus timeout.

## Operation
- **TX holding register:** one entry with a pend flag.
  - tx_ready = ~tx_pend.
  - A byte is accepted when tx_valid & tx_ready.
  - There is no same-cycle refill while pend is set.
- **RX output register:** one entry.
  - rx_valid is set when a byte is captured from the bus.
  - rx_valid clears when rx_valid & rx_ready.
- **FSM states:** IDLE, POLL, RD_RX, WR_TX.
- **IDLE:** the gap counter counts 0..POLL_GAP. The FSM enters POLL when the counter reaches POLL_GAP. Entering IDLE resets the counter.
- **POLL:** read_o=1, addr_o=BASE_ADDR+2.
  - On ack_i, capture rda=data_i[0] and tbr=data_i[1], then decide:
    - if rda & ~rx_valid, go to RD_RX;
    - else if tbr & tx_pend, go to WR_TX;
    - else go to IDLE.
  - RX has priority over TX to avoid overrun.
- **RD_RX:** read_o=1, addr_o=BASE_ADDR+1. On ack_i: rx_data <= data_i[7:0], rx_valid <= 1, go to IDLE.
- **WR_TX:** write_o=1, addr_o=BASE_ADDR, data_o={24'h0, tx byte}. On ack_i: clear tx_pend, go to IDLE.
- **Timeout:**
  - A counter increments each cycle a request is held and ack_i is low.
  - When it reaches TIMEOUT-1 without an ack: err_o pulses for 1 cycle, the request drops, and the FSM goes to IDLE.
  - A pending TX byte is retained and retried after a fresh poll. No RX byte is captured.
  - The counter clears on every state entry.
- write_o and read_o are never high together.
- Outside the request states, write_o=read_o=0, addr_o=0, data_o=0.

## Timing
- **Reset values:** state=IDLE, write_o=0, read_o=0, addr_o=0, data_o=0, tx_ready=1, rx_valid=0, rx_data=0, err_o=0, all counters 0.
- **Reset mid-operation:** asserting rst_n low clears everything asynchronously, so bus requests drop without waiting for a clock. A pending TX byte is lost.
- Bus outputs are Moore-decoded from registered state and registered byte storage. There is no combinational path from ack_i or data_i to any output.
- Each request is asserted from state entry and held until the edge where ack_i=1. The next cycle is IDLE, so a write strobe lasts exactly one cycle when the target acks immediately.
- **TX latency** with POLL_GAP=0 and immediate acks, byte accepted at edge N:
  - N+1: POLL.
  - N+2: WR_TX.
  - N+3: IDLE with tx_ready=1.
- **RX latency:** rx_valid rises on the edge after the RD_RX ack.
- rx_valid held high suppresses further RX reads. Status polls continue, and TX may still proceed.

## Structure
- **Package spart_pkg:**
  - offset localparams TX_OFF=2'd0, RX_OFF=2'd1, STAT_OFF=2'd2;
  - status bit indices RDA_BIT=0, TBR_BIT=1;
  - state enum typedef spart_bm_state_t.
- **Sub-module:** spart_bus_timer, the request timeout counter with clear, enable and expire outputs.
- Everything else lives in spart_bus_master.

## Test plan
1. **Reset:** hold rst_n=0, then release. All outputs are at their reset values, tx_ready=1, and after POLL_GAP+1 cycles read_o=1 with addr_o=0x1E.
2. **TX basic:** POLL_GAP=0, push 0xA5, status=0x2 with immediate ack. There is exactly one cycle of write_o=1 with addr_o=0x1C and data_o=0x000000A5, and tx_ready returns high at N+3.
3. **TX backpressure:**
   - status=0x0 for 3 polls, then 0x2;
   - no write occurs before the fourth poll;
   - exactly one write follows, and tx_ready stays 0 until then.
4. **RX with priority:**
   - status=0x3 with TX 0x11 pending and the RX register returning 0x3C;
   - a read of 0x1D precedes the write of 0x1C;
   - rx_data=0x3C and rx_valid stays held while rx_ready=0, with no second RX read;
   - rx_valid clears one cycle after rx_ready=1.
5. **Timeout:**
   - TIMEOUT=8 with ack_i stuck at 0 while TX 0x55 is pending;
   - read_o is high for 8 cycles, err_o pulses once, and the FSM returns to IDLE;
   - after the ack is restored, 0x55 is written.
6. **Async reset in WR_TX:** drive rst_n low mid-cycle while write_o=1. write_o drops before the next edge, and tx_ready=1 after release.
